// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants (FSM encoding, instruction width, PC step).
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the registered IF/ID entry.
// Latency: none; wiring only.
// Backpressure: imem_req is held with a stable imem_addr until imem_ack; IF/ID is held by the decode hazard.
// Ports: imem_req/imem_addr/imem_ack/imem_rdata, if_valid/if_instr/if_pc.
// master = fetch controller side, slave = memory + decode side.
interface fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  import cpu_pkg::*;

  logic               imem_req;
  logic [WIDTH-1:0]   imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [WIDTH-1:0]   if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a fetch that completed while decode was stalled.
// Latency: load visible one cycle later; clear dominates load, load dominates unload.
// Backpressure: none of its own; the owner only loads when empty.
// Ports: clk, rst (sync, active-low), load/unload/clear, in_instr/in_pc, vld/instr/pc.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [WIDTH-1:0]   in_pc,
  output logic               vld,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   pc
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      vld   <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      vld   <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (unload) begin
      vld   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC next/hold, runs the imem req/ack handshake, fills IF/ID, squashes on branches.
// Latency: instruction lands in IF/ID on the edge after its ack; zero-wait ack sustains 1 instr/cycle.
// Backpressure: decode hazard holds IF/ID; a fetch completing under hazard parks in the skid buffer.
// Ports: clk, rst (sync, active-low), pc_q/pc_d/pc_freeze, hazard, br_taken/br_addr, bus (fetch_ctrl_if.master).
// Optional: `define FETCH_PERF_CNT_EN adds perf_fetch/perf_stall/perf_flush counters.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_d,
  output logic             pc_freeze,
  input  logic             hazard,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_addr,
  fetch_ctrl_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush
`endif
);

  fetch_state_e       state_q, state_d;
  logic               req;
  logic [WIDTH-1:0]   redir_q, redir_d;
  logic               ifv_q, ifv_d;
  logic [INSTR_W-1:0] ifi_q, ifi_d;
  logic [WIDTH-1:0]   ifp_q, ifp_d;

  logic               skid_load, skid_unload, skid_clear;
  logic               skid_vld;
  logic [INSTR_W-1:0] skid_instr;
  logic [WIDTH-1:0]   skid_pc;

  fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .in_instr (bus.imem_rdata),
    .in_pc    (pc_q),
    .vld      (skid_vld),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // The fetch address is always the PC register; holding the PC holds the address.
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = ifv_q;
  assign bus.if_instr  = ifi_q;
  assign bus.if_pc     = ifp_q;

  always_comb begin
    state_d     = state_q;
    redir_d     = redir_q;
    ifv_d       = ifv_q;
    ifi_d       = ifi_q;
    ifp_d       = ifp_q;
    req         = 1'b0;
    pc_d        = pc_q + WIDTH'(PC_INC);
    pc_freeze   = 1'b1;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (!rst) begin
      pc_d = RESET_PC;
    end else begin
      case (state_q)
        FETCH: begin
          req = 1'b1;
          if (br_taken) begin
            ifv_d = 1'b0;
            if (bus.imem_ack) begin
              pc_d      = br_addr;
              pc_freeze = 1'b0;
            end else begin
              // Request cannot be withdrawn; remember the target and wait it out.
              redir_d = br_addr;
              state_d = DROP;
            end
          end else if (bus.imem_ack) begin
            if (!hazard) begin
              ifv_d     = 1'b1;
              ifi_d     = bus.imem_rdata;
              ifp_d     = pc_q;
              pc_freeze = 1'b0;
            end else begin
              // PC stays on the parked word so HOLD can advance it on release.
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (!hazard) begin
            ifv_d = 1'b0;
          end
        end

        HOLD: begin
          if (br_taken) begin
            skid_clear = 1'b1;
            ifv_d      = 1'b0;
            pc_d       = br_addr;
            pc_freeze  = 1'b0;
            state_d    = FETCH;
          end else if (!hazard) begin
            skid_unload = 1'b1;
            ifv_d       = skid_vld;
            ifi_d       = skid_instr;
            ifp_d       = skid_pc;
            pc_freeze   = 1'b0;
            state_d     = FETCH;
          end
        end

        DROP: begin
          req = 1'b1;
          if (br_taken) redir_d = br_addr;
          if (br_taken || !hazard) ifv_d = 1'b0;
          if (bus.imem_ack) begin
            pc_d      = br_taken ? br_addr : redir_q;
            pc_freeze = 1'b0;
            state_d   = FETCH;
          end
        end

        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      redir_q <= '0;
      ifv_q   <= 1'b0;
      ifi_q   <= '0;
      ifp_q   <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      ifv_q   <= ifv_d;
      ifi_q   <= ifi_d;
      ifp_q   <= ifp_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // An ack in FETCH without a branch is a fetch kept (into IF/ID or the skid).
  logic accept;
  assign accept = (state_q == FETCH) && bus.imem_ack && !br_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (accept)    perf_fetch <= perf_fetch + 32'd1;
      if (pc_freeze) perf_stall <= perf_stall + 32'd1;
      if (br_taken)  perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import cpu_pkg::*;

  localparam int             W      = 32;
  localparam logic [W-1:0]   RST_PC = '0;
  localparam int             NCYC   = 4000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_q, pc_d, br_addr;
  logic         pc_freeze, hazard, br_taken;

  fetch_ctrl_if #(.WIDTH(W)) bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  fetch_ctrl #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_q      (pc_q),
    .pc_d      (pc_d),
    .pc_freeze (pc_freeze),
    .hazard    (hazard),
    .br_taken  (br_taken),
    .br_addr   (br_addr),
    .bus       (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_1E69;
  endfunction

  typedef struct packed {
    logic [31:0]  instr;
    logic [W-1:0] pc;
  } ent_t;

  // Scoreboard: words decode must see, in program order.
  ent_t exp_q[$];

  // Reference model: next address to fetch, squash of an in-flight fetch, parked word.
  logic [W-1:0] m_pc;
  bit           m_sq;
  bit           m_skv;
  ent_t         m_sk;

  // ---------------- monitor ----------------
  bit e_rst, e_haz, e_br;
  bit mon_en = 1'b0;
  logic         p_v;
  logic [31:0]  p_i;
  logic [W-1:0] p_p;

  always @(posedge clk) begin
    e_rst  = rst;
    e_haz  = hazard;
    e_br   = br_taken;
    mon_en = 1'b1;
  end

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      if (!e_rst)
        chk(bus.if_valid === 1'b0, "reset_ifvalid", 64'(bus.if_valid), 64'd0);
      else if (e_br)
        chk(bus.if_valid === 1'b0, "branch_flush_ifvalid", 64'(bus.if_valid), 64'd0);
      else if (e_haz)
        chk({bus.if_valid, bus.if_instr, bus.if_pc} === {p_v, p_i, p_p}, "hazard_hold_ifid",
            {bus.if_instr, bus.if_pc}, {p_i, p_p});
      else if (bus.if_valid === 1'b1) begin
        chk(exp_q.size() != 0, "unexpected_instr", {bus.if_instr, bus.if_pc}, 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({bus.if_instr, bus.if_pc} === e, "ifid_word", {bus.if_instr, bus.if_pc}, e);
        end
      end
      p_v = bus.if_valid;
      p_i = bus.if_instr;
      p_p = bus.if_pc;
    end
  end

  // ---------------- stimulus, memory, PC register, model ----------------
  initial begin
    int           wait_left;
    int           rst_hold;
    int           flush_cnt;
    logic [W-1:0] pc_nxt;
    ent_t         e;

    rst = 1'b0; hazard = 1'b0; br_taken = 1'b0; br_addr = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    pc_q = RST_PC; pc_nxt = RST_PC;
    wait_left = -1; rst_hold = 3; flush_cnt = 0;
    m_pc = RST_PC; m_sq = 1'b0; m_skv = 1'b0; m_sk = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      pc_q = pc_nxt;

      if (rst_hold > 0) begin
        rst = 1'b0; rst_hold--;
      end else if (cyc > 60 && cyc < NCYC - 20 && $urandom_range(0, 249) == 0) begin
        rst = 1'b0; rst_hold = int'($urandom_range(0, 2));
      end else begin
        rst = 1'b1;
      end

      if (cyc < 40 || cyc >= NCYC - 20) begin
        hazard = 1'b0; br_taken = 1'b0;
      end else begin
        hazard   = ($urandom_range(0, 2) == 0);
        br_taken = ($urandom_range(0, 6) == 0);
        br_addr  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (W'($urandom_range(0, 1023)) << 2);
      end

      #1;
      if (!rst) begin
        wait_left = -1; bus.imem_ack = 1'b0;
      end else if (bus.imem_req) begin
        if (wait_left < 0)
          wait_left = (cyc < 40 || $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
        bus.imem_ack   = (wait_left == 0);
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        wait_left = -1; bus.imem_ack = 1'b0;
      end

      #1;
      if (!rst) begin
        chk(bus.imem_req === 1'b0, "reset_req", 64'(bus.imem_req), 64'd0);
        chk(pc_freeze === 1'b1, "reset_freeze", 64'(pc_freeze), 64'd1);
        chk(pc_d === RST_PC, "reset_pcd", 64'(pc_d), 64'(RST_PC));
        m_pc = RST_PC; m_sq = 1'b0; m_skv = 1'b0; flush_cnt = 0;
      end else begin
        if (m_skv)
          chk(bus.imem_req === 1'b0, "hold_req", 64'(bus.imem_req), 64'd0);
        if (bus.imem_req && !m_sq)
          chk(bus.imem_addr === m_pc, "fetch_addr", 64'(bus.imem_addr), 64'(m_pc));
        if (bus.imem_req && !bus.imem_ack)
          chk(pc_freeze === 1'b1, "wait_freeze", 64'(pc_freeze), 64'd1);

        if (br_taken) begin
          flush_cnt++;
          if (!(bus.imem_req && !bus.imem_ack))
            chk({pc_freeze, pc_d} === {1'b0, br_addr}, "branch_pcd", {pc_freeze, pc_d}, {1'b0, br_addr});
          m_sq  = bus.imem_req && !bus.imem_ack;
          m_pc  = br_addr;
          m_skv = 1'b0;
        end else if (m_skv) begin
          if (!hazard) begin
            chk({pc_freeze, pc_d} === {1'b0, m_pc}, "skid_release_pcd", {pc_freeze, pc_d}, {1'b0, m_pc});
            exp_q.push_back(m_sk);
            m_skv = 1'b0;
          end else begin
            chk(pc_freeze === 1'b1, "skid_hold_freeze", 64'(pc_freeze), 64'd1);
          end
        end else if (bus.imem_req && bus.imem_ack) begin
          if (m_sq) begin
            chk({pc_freeze, pc_d} === {1'b0, m_pc}, "redirect_pcd", {pc_freeze, pc_d}, {1'b0, m_pc});
            m_sq = 1'b0;
          end else begin
            e.instr = mem_word(m_pc);
            e.pc    = m_pc;
            m_pc    = m_pc + W'(PC_INC);
            if (hazard) begin
              chk(pc_freeze === 1'b1, "skid_load_freeze", 64'(pc_freeze), 64'd1);
              m_sk  = e;
              m_skv = 1'b1;
            end else begin
              chk({pc_freeze, pc_d} === {1'b0, m_pc}, "fetch_pcd", {pc_freeze, pc_d}, {1'b0, m_pc});
              exp_q.push_back(e);
            end
          end
        end
      end

      pc_nxt = (!rst || !pc_freeze) ? pc_d : pc_q;
      if (bus.imem_ack) wait_left = -1;
      else if (wait_left > 0) wait_left--;
    end

    @(posedge clk);
    @(negedge clk); #1;
    chk(exp_q.size() == 0, "scoreboard_drain", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk(perf_flush === 32'(flush_cnt), "perf_flush", 64'(perf_flush), 64'(flush_cnt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
